lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 clk  in  1  single clock; all state on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 ex_valid  in  1  memory-stage instruction valid.
REQ-004 mem_read  in  1  load request from main control.
REQ-005 mem_write  in  1  store request from main control.
REQ-006 funct3  in  3  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-007 addr  in  32  byte address from ALU.
REQ-008 wdata  in  32  store data (rs2).
REQ-009 stall  out  1  freeze upstream pipeline.
REQ-010 load_valid  out  1  one-cycle pulse, load_data valid.
REQ-011 load_data  out  32  aligned, extended load result.
REQ-012 misaligned  out  1  one-cycle misaligned-access flag.
REQ-013 dmem_req, dmem_we  out  1 each  bus request, write enable.
REQ-014 dmem_addr  out  32  word-aligned address (addr[1:0]=0).
REQ-015 dmem_be, dmem_wdata  out  4/32  byte enables, lane-replicated data.
REQ-016 dmem_gnt, dmem_rvalid  in  1 each  grant, read-data valid.
REQ-017 dmem_rdata  in  32  read data.

Function
REQ-018 FSM states IDLE, REQ, WAIT; accept = IDLE & ex_valid & (mem_read XOR mem_write).
REQ-019 On accept: latch addr/funct3/wdata/we, go to REQ; stall asserted combinationally in the accept cycle.
REQ-020 REQ: dmem_req=1; all dmem_* held stable until dmem_gnt; on gnt, store -> IDLE, load -> WAIT.
REQ-021 WAIT: dmem_req=0; on dmem_rvalid, register extracted data into load_data, go to IDLE; load_valid=1 in the following cycle.
REQ-022 stall = (state != IDLE) | accept; load_valid coincides with stall=0.
REQ-023 dmem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-024 dmem_wdata: byte replicated x4, half replicated x2, word as is.
REQ-025 Load extraction by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-026 Unsupported funct3 values (3, 6, 7) SHALL be treated as word access.
REQ-027 mem_read & mem_write both 1 SHALL be a no-op: no request, no stall.
REQ-028 dmem_rvalid in IDLE or REQ SHALL be ignored; ex_valid outside IDLE ignored.
REQ-029 Store-to-grant minimum latency 1 cycle; load-to-load_valid minimum 3 cycles (accept, REQ w/ gnt, WAIT w/ rvalid, pulse).

Reset
REQ-030 rst asynchronously forces IDLE; dmem_req, dmem_we, dmem_be, stall (registered part), load_valid, misaligned, load_data, dmem_addr, dmem_wdata = 0.
REQ-031 Reset mid-transaction abandons it; no load_valid afterwards.

Configuration
REQ-032 LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 issues no bus request, pulses misaligned one cycle after accept condition, stays IDLE, no stall.
REQ-033 Undefined: misaligned tied 0; access performed with lane rules of REQ-023/025 (possibly truncated).

Structure
REQ-034 Shared package riscv_pkg: funct3 load/store encodings, lsu_state_e enum.
REQ-035 Sub-module lsu_align: combinational byte-enable, store-lane and load-extraction logic.

Verification
REQ-036 SW addr=0x104 wdata=0xDEADBEEF, gnt after 2 cycles -> be=1111, addr=0x104, stall 3 cycles.
REQ-037 LB addr=0x103, rdata=0x80FFFFFF -> load_data=0xFFFFFF80; LBU -> 0x00000080.
REQ-038 SH addr=0x102 wdata=0x1234 -> be=1100, dmem_wdata=0x12341234.
REQ-039 LH addr=0x101 with macro -> misaligned=1, dmem_req never 1; without -> request issued.
REQ-040 rst asserted in WAIT -> dmem_req=0, stall=0 immediately, later rvalid produces no load_valid.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V LSU definitions: funct3 load/store encodings, FSM state type,
// access-size decode and alignment helpers.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_e;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} lsu_size_e;

  // Unsupported encodings (3, 6, 7) fall through to word access.
  function automatic lsu_size_e f3_size(logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_BYTE;
      F3_LH, F3_LHU: return SZ_HALF;
      default:       return SZ_WORD;
    endcase
  endfunction

  function automatic logic f3_misaligned(logic [2:0] f3, logic [1:0] a);
    case (f3_size(f3))
      SZ_BYTE: return 1'b0;
      SZ_HALF: return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
interface lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication and
// load-data extraction with sign/zero extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_ext
);

  logic [31:0] shifted;
  logic [15:0] half_sel;
  logic        sign;

  // Store side: byte enables and replicated write lanes.
  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    case (f3_size(funct3))
      SZ_BYTE: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        wdata_lane = wdata;
      end
    endcase
  end

  // Load side: pick the addressed lane and extend it.
  always_comb begin
    shifted  = rdata >> {addr_lo, 3'b000};
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    sign     = ~funct3[2];
    load_ext = rdata;
    case (f3_size(funct3))
      SZ_BYTE: load_ext = {{24{sign & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_ext = {{16{sign & half_sel[15]}}, half_sel};
      default: load_ext = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single outstanding access over a req/gnt/rvalid bus.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses
// raise a one-cycle misaligned pulse instead of going to the bus.
module lsu
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        misaligned,
  lsu_if.master       dmem
);

  lsu_state_e  state, state_n;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic        accept, go, rsp;
  logic [3:0]  be;
  logic [31:0] wdata_lane, load_ext;

  assign accept = (state == IDLE) & ex_valid & (mem_read ^ mem_write);
  assign rsp    = (state == WAIT) & dmem.dmem_rvalid;

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_raw;
  assign mis_raw = accept & f3_misaligned(funct3, addr[1:0]);
  assign go      = accept & ~mis_raw;

  // Misaligned pulse one cycle after the offending accept condition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misaligned <= 1'b0;
    else     misaligned <= mis_raw;
  end
`else
  assign go         = accept;
  assign misaligned = 1'b0;
`endif

  lsu_align u_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (dmem.dmem_rdata),
    .be         (be),
    .wdata_lane (wdata_lane),
    .load_ext   (load_ext)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and bus/stall outputs.
  always_comb begin
    state_n          = state;
    stall            = (state != IDLE) | go;
    dmem.dmem_req    = (state == REQ);
    dmem.dmem_we     = (state == REQ) & we_q;
    dmem.dmem_be     = (state == REQ) ? be : '0;
    dmem.dmem_addr   = {addr_q[31:2], 2'b00};
    dmem.dmem_wdata  = wdata_lane;
    case (state)
      IDLE:    if (go) state_n = REQ;
      REQ:     if (dmem.dmem_gnt) state_n = we_q ? IDLE : WAIT;
      WAIT:    if (dmem.dmem_rvalid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Latch the request on accept; held stable through REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
    end else if (go) begin
      addr_q   <= addr;
      wdata_q  <= wdata;
      funct3_q <= funct3;
      we_q     <= mem_write;
    end
  end

  // Register the extracted load result and its one-cycle valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_valid <= 1'b0;
      load_data  <= '0;
    end else begin
      load_valid <= rsp;
      if (rsp) load_data <= load_ext;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a bus/load scoreboard.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, load_valid, misaligned;
  logic [31:0] load_data;

  int checks = 0;
  int errors = 0;
  int stall_cnt;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] ld_q[$];

  lsu_if bus ();

  lsu u_dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .load_valid (load_valid),
    .load_data  (load_data),
    .misaligned (misaligned),
    .dmem       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model, written independently of the RTL structure.
  function automatic int sz(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] r = '0;
    for (int i = 0; i < sz(f3); i++) r[(a[1:0] & ~(sz(f3) - 1)) + i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] d);
    if (sz(f3) == 1) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (sz(f3) == 2) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int   base = int'(a[1:0] & ~(sz(f3) - 1)) * 8;
    logic [31:0] v = '0;
    if (sz(f3) == 4) return rd;
    for (int i = 0; i < sz(f3) * 8; i++) v[i] = rd[base + i];
    if (f3[2] == 1'b0)
      for (int i = sz(f3) * 8; i < 32; i++) v[i] = rd[base + sz(f3) * 8 - 1];
    return v;
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
    return (sz(f3) == 2 && a[0]) || (sz(f3) == 4 && a[1:0] != 2'b00);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_stall(input string tag, input logic exp);
    chk(tag, stall, exp);
    if (stall) stall_cnt++;
  endtask

  // One full access: accept, gdly REQ cycles without grant, grant, then for
  // loads rdly WAIT cycles before rvalid and the load_valid pulse.
  task automatic do_access(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int gdly, input int rdly, input logic [3:0] ebe,
                           input logic [31:0] ewd, input logic [31:0] eld);
    bus_t e, got;
    e.we = ~ld; e.addr = {a[31:2], 2'b00}; e.be = ebe; e.wd = ewd;
    bus_q.push_back(e);
    if (ld) ld_q.push_back(eld);
    stall_cnt = 0;
    ex_valid = 1'b1; mem_read = ld; mem_write = ~ld; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    sample_stall("accept_stall", 1'b1);
    chk("accept_no_req", bus.dmem_req, 1'b0);
    step();
    ex_valid = 1'b0; addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = $urandom;
    for (int i = 0; i < gdly; i++) begin
      @(negedge clk);
      sample_stall("req_stall", 1'b1);
      chk("req_hold_req", bus.dmem_req, 1'b1);
      chk("req_hold_addr", bus.dmem_addr, e.addr);
      chk("req_hold_be", bus.dmem_be, e.be);
      step();
    end
    bus.dmem_gnt = 1'b1; bus.dmem_rvalid = 1'b0;
    @(negedge clk);
    sample_stall("gnt_stall", 1'b1);
    got = bus_q.pop_front();
    chk("gnt_req", bus.dmem_req, 1'b1);
    chk("gnt_we", bus.dmem_we, got.we);
    chk("gnt_addr", bus.dmem_addr, got.addr);
    chk("gnt_be", bus.dmem_be, got.be);
    if (!ld) chk("gnt_wdata", bus.dmem_wdata, got.wd);
    step();
    bus.dmem_gnt = 1'b0;
    if (!ld) begin
      @(negedge clk);
      sample_stall("store_done_stall", 1'b0);
      chk("store_done_req", bus.dmem_req, 1'b0);
      chk("store_stall_cycles", stall_cnt, 2 + gdly);
    end else begin
      for (int i = 0; i < rdly; i++) begin
        @(negedge clk);
        sample_stall("wait_stall", 1'b1);
        chk("wait_no_req", bus.dmem_req, 1'b0);
        step();
      end
      bus.dmem_rvalid = 1'b1; bus.dmem_rdata = rd;
      @(negedge clk);
      sample_stall("rvalid_stall", 1'b1);
      chk("rvalid_no_lv", load_valid, 1'b0);
      step();
      bus.dmem_rvalid = 1'b0; bus.dmem_rdata = $urandom;
      @(negedge clk);
      sample_stall("lv_stall", 1'b0);
      chk("load_valid", load_valid, 1'b1);
      chk("load_data", load_data, ld_q.pop_front());
      chk("load_stall_cycles", stall_cnt, 3 + gdly + rdly);
      step();
      @(negedge clk);
      chk("load_valid_pulse", load_valid, 1'b0);
    end
    step();
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, wd, rd;
    logic        ld;
    logic [2:0]  f3_tab [8];
    f3_tab[0] = 3'd0; f3_tab[1] = 3'd1; f3_tab[2] = 3'd2; f3_tab[3] = 3'd3;
    f3_tab[4] = 3'd4; f3_tab[5] = 3'd5; f3_tab[6] = 3'd6; f3_tab[7] = 3'd7;

    rst = 1'b1; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = '0; addr = '0; wdata = '0;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 1'b0);
    chk("rst_req", bus.dmem_req, 1'b0);
    chk("rst_we", bus.dmem_we, 1'b0);
    chk("rst_be", bus.dmem_be, 4'b0000);
    chk("rst_addr", bus.dmem_addr, 32'h0);
    chk("rst_wdata", bus.dmem_wdata, 32'h0);
    chk("rst_lv", load_valid, 1'b0);
    chk("rst_ld", load_data, 32'h0);
    chk("rst_mis", misaligned, 1'b0);
    step();
    rst = 1'b0;
    step();

    // SW with grant in the second REQ cycle: three stall cycles.
    do_access(1'b0, 3'd2, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 1, 0,
              4'b1111, 32'hDEAD_BEEF, 32'h0);
    // LB / LBU from the top byte lane.
    do_access(1'b1, 3'd0, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 0, 0,
              4'b1000, 32'h0, 32'hFFFF_FF80);
    do_access(1'b1, 3'd4, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 2, 1,
              4'b1000, 32'h0, 32'h0000_0080);
    // SH upper half: replicated lanes.
    do_access(1'b0, 3'd1, 32'h0000_0102, 32'h0000_1234, 32'h0, 0, 0,
              4'b1100, 32'h1234_1234, 32'h0);
    // Unsupported funct3 acts as word.
    do_access(1'b1, 3'd7, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 0, 2,
              4'b1111, 32'h0, 32'hCAFE_F00D);

    // Misaligned LH at 0x101.
`ifdef LSU_MISALIGN_TRAP_EN
    ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd1; addr = 32'h101;
    @(negedge clk);
    chk("mis_no_stall", stall, 1'b0);
    chk("mis_no_req0", bus.dmem_req, 1'b0);
    step();
    ex_valid = 1'b0;
    @(negedge clk);
    chk("mis_pulse", misaligned, 1'b1);
    chk("mis_no_req1", bus.dmem_req, 1'b0);
    chk("mis_idle_stall", stall, 1'b0);
    step();
    @(negedge clk);
    chk("mis_pulse_end", misaligned, 1'b0);
    chk("mis_no_req2", bus.dmem_req, 1'b0);
    step();
`else
    do_access(1'b1, 3'd1, 32'h0000_0101, 32'h0, 32'h1234_F00D, 0, 0,
              4'b0011, 32'h0, 32'hFFFF_F00D);
    chk("mis_tied0", misaligned, 1'b0);
`endif

    // mem_read and mem_write together: no-op.
    ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b1; funct3 = 3'd2; addr = 32'h300;
    @(negedge clk);
    chk("both_no_stall", stall, 1'b0);
    step();
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    chk("both_no_req", bus.dmem_req, 1'b0);
    step();

    // Reset while waiting for read data.
    ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd2; addr = 32'h400;
    step();
    ex_valid = 1'b0; bus.dmem_gnt = 1'b1;
    step();
    bus.dmem_gnt = 1'b0;
    @(negedge clk);
    chk("wait_before_rst_stall", stall, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rst_wait_req", bus.dmem_req, 1'b0);
    chk("rst_wait_stall", stall, 1'b0);
    step();
    rst = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h5555_AAAA;
    step();
    bus.dmem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_lv", load_valid, 1'b0);
      chk("rst_no_stall", stall, 1'b0);
      step();
    end

    // Randomised accesses against the reference model.
    for (int n = 0; n < 12; n++) begin
      ld = 1'($urandom);
      f3 = f3_tab[$urandom_range(0, 7)];
      if (!ld && f3 > 3'd2) f3 = 3'd2 - 3'(n % 3);
      a = $urandom; wd = $urandom; rd = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
      if (m_mis(f3, a)) a[1:0] = 2'b00;
`endif
      do_access(ld, f3, a, wd, rd, $urandom_range(0, 2), $urandom_range(0, 2),
                m_be(f3, a), m_wd(f3, wd), m_ld(f3, a, rd));
    end

    chk("sb_bus_empty", bus_q.size(), 0);
    chk("sb_ld_empty", ld_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
